// File: rtl/gray_step_checker.sv
// Gray-code step checker: decodes gray samples to binary, flags multi-bit steps, tracks lock and step direction.
// Define GRAY_CHK_STICKY_ERR_EN to make step_err hold at 1 until reset instead of pulsing.
module gray_step_checker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned RELOCK    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_err,
    output logic                 dir_up,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned GOOD_W = $clog2(RELOCK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_FAULT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GOOD_W-1:0]   r_good;
    logic [GOOD_W-1:0]   w_good_nxt;
    logic [WIDTH-1:0]    r_prev_gray;
    logic [WIDTH-1:0]    r_prev_bin;
    logic [WIDTH-1:0]    w_bin;
    logic [WIDTH-1:0]    w_diff;
    logic [WIDTH-1:0]    w_prev_inc;
    logic                w_dist_zero;
    logic                w_dist_one;
    logic                w_dist_many;
    logic                w_err_hit;
    logic                w_dir_nxt;
    logic                w_step_err_nxt;

    // b[i] is the XOR of all gray bits at or above position i
    always_comb begin
        w_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(gray_in >> i);
        end
    end

    // Hamming distance is only ever classified as 0, 1 or more
    assign w_diff      = gray_in ^ r_prev_gray;
    assign w_dist_zero = (w_diff == '0);
    assign w_dist_one  = !w_dist_zero && ((w_diff & (w_diff - WIDTH'(1))) == '0);
    assign w_dist_many = !w_dist_zero && !w_dist_one;
    assign w_prev_inc  = r_prev_bin + WIDTH'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err_hit   = 1'b0;
        w_dir_nxt   = dir_up;
        if (in_valid) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_TRACK;
                    w_good_nxt  = '0;
                end
                S_TRACK: begin
                    if (w_dist_many) begin
                        w_err_hit   = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = S_FAULT;
                    end else if (w_dist_one) begin
                        w_dir_nxt = (w_bin == w_prev_inc);
                    end
                end
                S_FAULT: begin
                    if (w_dist_many) begin
                        w_err_hit  = 1'b1;
                        w_good_nxt = '0;
                    end else if (w_dist_one) begin
                        w_dir_nxt = (w_bin == w_prev_inc);
                        if (r_good == GOOD_W'(RELOCK - 1)) begin
                            w_state_nxt = S_TRACK;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt = r_good + GOOD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

`ifdef GRAY_CHK_STICKY_ERR_EN
    assign w_step_err_nxt = step_err | (in_valid & w_err_hit);
`else
    assign w_step_err_nxt = in_valid & w_err_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_gray <= '0;
            r_prev_bin  <= '0;
            out_valid   <= 1'b0;
            bin_out     <= '0;
            step_err    <= 1'b0;
            dir_up      <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            out_valid <= in_valid;
            step_err  <= w_step_err_nxt;
            if (in_valid) begin
                r_prev_gray <= gray_in;
                r_prev_bin  <= w_bin;
                bin_out     <= w_bin;
                dir_up      <= w_dir_nxt;
                locked      <= (w_state_nxt == S_TRACK);
                if (w_err_hit && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_step_checker.sv
// Scoreboard bench for gray_step_checker: directed gray vectors with hand-computed expectations.
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_gray_step_checker;

`ifdef GRAY_CHK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] gray_in;
    logic       out_valid;
    logic [3:0] bin_out;
    logic       step_err;
    logic       dir_up;
    logic       locked;
    logic [7:0] err_count;
    logic       out_valid2;
    logic [3:0] bin_out2;
    logic       step_err2;
    logic       dir_up2;
    logic       locked2;
    logic [1:0] err_count2;

    always #5 clk = ~clk;

    gray_step_checker #(.WIDTH(4), .ERR_CNT_W(8), .RELOCK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .out_valid(out_valid), .bin_out(bin_out), .step_err(step_err),
        .dir_up(dir_up), .locked(locked), .err_count(err_count)
    );

    gray_step_checker #(.WIDTH(4), .ERR_CNT_W(2), .RELOCK(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .out_valid(out_valid2), .bin_out(bin_out2), .step_err(step_err2),
        .dir_up(dir_up2), .locked(locked2), .err_count(err_count2)
    );

    typedef struct {
        logic [3:0] bin;
        logic       err;
        logic       dir;
        logic       dchk;
        logic       lock;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic sticky_seen;

    logic [3:0] gtab [0:15] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    task automatic send(input logic [3:0] g, input int b, input logic e, input logic d,
                        input logic dc, input logic l, input int c);
        exp_t x;
        in_valid = 1'b1;
        gray_in  = g;
        if (e) sticky_seen = 1'b1;
        x.bin  = 4'(b);
        x.err  = STICKY ? sticky_seen : e;
        x.dir  = d;
        x.dchk = dc;
        x.lock = l;
        x.cnt  = c;
        q.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (out_valid !== 1'b0 || bin_out !== 4'd0 || step_err !== 1'b0 || dir_up !== 1'b0 ||
            locked !== 1'b0 || err_count !== 8'd0 || err_count2 !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got v=%b bin=%0d err=%b dir=%b lock=%b cnt=%0d cnt2=%0d, want all zero",
                     name, out_valid, bin_out, step_err, dir_up, locked, err_count, err_count2);
        end
    endtask

    // Monitor: every presented output must match the oldest outstanding expectation
    exp_t       m;
    logic [1:0] c2e;
    bit         mok;
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_valid: got out_valid=1 bin=%0d, want no output", bin_out);
            end else begin
                m   = q.pop_front();
                c2e = (m.cnt > 3) ? 2'd3 : 2'(m.cnt);
                mok = (bin_out === m.bin) && (step_err === m.err) && (locked === m.lock) &&
                      (err_count === 8'(m.cnt)) && (err_count2 === c2e) &&
                      (!m.dchk || dir_up === m.dir);
                if (!mok) begin
                    n_bad++;
                    $display("FAIL vec%0d: got bin=%0d err=%b dir=%b lock=%b cnt=%0d cnt2=%0d; want bin=%0d err=%b dir=%b(chk=%b) lock=%b cnt=%0d cnt2=%0d",
                             n_vec, bin_out, step_err, dir_up, locked, err_count, err_count2,
                             m.bin, m.err, m.dir, m.dchk, m.lock, m.cnt, c2e);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        gray_in     = 4'd0;
        sticky_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_init");
        rst = 1'b0;

        // Full up-count: first sample takes the IDLE path, so dir_up is still 0 there
        for (int i = 0; i < 16; i++) send(gtab[i], i, 1'b0, (i != 0), 1'b1, 1'b1, 0);

        // Wrap up then wrap down
        send(4'b0000, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        send(4'b1000, 15, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Walk down to 10, idle gap, repeat 10
        for (int i = 14; i >= 10; i--) send(gtab[i], i, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || bin_out !== 4'd10 || locked !== 1'b1 || dir_up !== 1'b0 ||
            step_err !== 1'b0 || err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL gap_hold: got v=%b bin=%0d lock=%b dir=%b err=%b cnt=%0d, want v=0 bin=10 lock=1 dir=0 err=0 cnt=0",
                     out_valid, bin_out, locked, dir_up, step_err, err_count);
        end
        send(4'b1111, 10, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Down to 0, then a 2-bit jump and relock after two good steps
        for (int i = 9; i >= 0; i--) send(gtab[i], i, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send(4'b0011, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        send(4'b0010, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        send(4'b0110, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        send(4'b0111, 5, 1'b0, 1'b1, 1'b1, 1'b1, 1);

        // FAULT: error resets good count, repeats do not count, counter saturation
        send(4'b0000, 0, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        send(4'b0001, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        send(4'b0100, 7, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        send(4'b0101, 6, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        send(4'b0111, 5, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        send(4'b1000, 15, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        send(4'b1000, 15, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        send(4'b1001, 14, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        send(4'b1000, 15, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        send(4'b0000, 0, 1'b0, 1'b1, 1'b1, 1'b1, 4);

        // Enter FAULT, then reset with a simultaneous valid sample
        send(4'b0011, 2, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        rst      = 1'b1;
        in_valid = 1'b1;
        gray_in  = 4'b0110;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        in_valid    = 1'b0;
        sticky_seen = 1'b0;
        check_reset("reset_fault");

        // First sample after reset is unchecked even though it is far from zero
        send(4'b1111, 10, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send(4'b1110, 11, 1'b0, 1'b1, 1'b1, 1'b1, 0);

        repeat (3) @(posedge clk);
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d outstanding expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
